// File: rtl/bti_pkg.sv
// Shared BTI bus definitions: tid width, request/response packets, word size.
// BTI_TIDW may be overridden with a define before this file is read.
`ifndef BTI_TIDW
`define BTI_TIDW 4
`endif

package bti_pkg;

    localparam int unsigned BTI_TIDW       = `BTI_TIDW;
    localparam int unsigned BTI_WORD_BYTES = 4;
    localparam int unsigned BTI_PKT_AW     = 32;
    localparam int unsigned BTI_PKT_DW     = 32;

    typedef struct packed {
        logic [BTI_PKT_AW-1:0]     addr;
        logic [BTI_TIDW-1:0]       tid;
        logic                      we;
        logic [BTI_WORD_BYTES-1:0] be;
        logic [BTI_PKT_DW-1:0]     wdata;
    } bti_req_pkt_t;

    typedef struct packed {
        logic [BTI_TIDW-1:0]   tid;
        logic [BTI_PKT_DW-1:0] data;
        logic                  ok;
    } bti_rsp_pkt_t;

endpackage

// File: rtl/bti_if.sv
// BTI request and response channel interfaces (valid/ready plus packet).
interface bti_req_if_t;
    import bti_pkg::*;
    logic         vld;
    logic         rdy;
    bti_req_pkt_t pkt;
    modport mst (output vld, output pkt, input rdy);
    modport slv (input vld, input pkt, output rdy);
endinterface

interface bti_rsp_if_t;
    import bti_pkg::*;
    logic         vld;
    logic         rdy;
    bti_rsp_pkt_t pkt;
    modport mst (output vld, output pkt, input rdy);
    modport slv (input vld, input pkt, output rdy);
endinterface

// File: rtl/bti_rsp_fifo.sv
// Synchronous response FIFO with registered storage and occupancy count.
module bti_rsp_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [DW-1:0]              push_data,
    input  logic                       pop,
    output logic [DW-1:0]              pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    assign full     = (count == (PW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bti_burst_rd.sv
// BTI burst read initiator: one command becomes a credit-limited stream of
// single-word reads. Define BTI_BURST_RD_TID_CHK_EN to flag response tid mismatches.
module bti_burst_rd
    import bti_pkg::*;
#(
    parameter int unsigned BTI_AW     = BTI_PKT_AW,
    parameter int unsigned BTI_DW     = BTI_PKT_DW,
    parameter int unsigned LEN_W      = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_vld,
    output logic              cmd_rdy,
    input  logic [BTI_AW-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    bti_req_if_t.mst          bti_req_mst,
    bti_rsp_if_t.slv          bti_rsp_slv,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [BTI_DW-1:0] out_data,
    output logic              done,
    output logic              err
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [BTI_AW-1:0]   addr_q;
    logic [BTI_TIDW-1:0] tid_q;
    logic [LEN_W-1:0]    issue_cnt;
    logic [LEN_W-1:0]    rsp_cnt;
    logic [CNT_W-1:0]    outstanding;
    logic [CNT_W-1:0]    fifo_count;
    logic [CNT_W:0]      inflight;
    logic                fifo_empty;
    logic                fifo_full_unused;
    logic                credit_ok;
    logic                req_vld;
    logic                req_fire;
    logic                rsp_fire;
    logic                cmd_fire;
    logic                rsp_bad;
    logic                done_q;
    logic                err_q;

    // Outstanding requests plus buffered words never exceed the FIFO depth,
    // so every response has a slot and the response channel can stay ready.
    assign inflight  = {1'b0, outstanding} + {1'b0, fifo_count};
    assign credit_ok = (inflight < (CNT_W+1)'(FIFO_DEPTH));

    assign req_fire = req_vld & bti_req_mst.rdy;
    assign rsp_fire = bti_rsp_slv.vld & bti_rsp_slv.rdy;
    assign cmd_fire = cmd_vld & cmd_rdy;

    assign bti_req_mst.vld = req_vld;
    assign bti_rsp_slv.rdy = 1'b1;
    assign out_vld         = ~fifo_empty;
    assign done            = done_q;
    assign err             = err_q;

    always_comb begin
        bti_req_mst.pkt      = '0;
        bti_req_mst.pkt.addr = BTI_PKT_AW'(addr_q);
        bti_req_mst.pkt.tid  = tid_q;
    end

`ifdef BTI_BURST_RD_TID_CHK_EN
    logic [BTI_TIDW-1:0] exp_tid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_tid <= '0;
        end else if (rsp_fire) begin
            exp_tid <= exp_tid + BTI_TIDW'(1);
        end
    end

    assign rsp_bad = ~bti_rsp_slv.pkt.ok | (bti_rsp_slv.pkt.tid != exp_tid);
`else
    logic unused_rsp_tid;
    assign unused_rsp_tid = ^bti_rsp_slv.pkt.tid;
    assign rsp_bad        = ~bti_rsp_slv.pkt.ok;
`endif

    always_comb begin
        state_nxt = state;
        cmd_rdy   = 1'b0;
        req_vld   = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_rdy = 1'b1;
                if (cmd_vld) begin
                    state_nxt = (cmd_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                req_vld = (issue_cnt != '0) && credit_ok;
                if (req_vld && bti_req_mst.rdy && issue_cnt == LEN_W'(1)) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (rsp_cnt == '0 && fifo_empty) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            tid_q       <= '0;
            issue_cnt   <= '0;
            rsp_cnt     <= '0;
            outstanding <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= (state == ST_DONE);

            if (cmd_fire) begin
                addr_q    <= cmd_addr & ~BTI_AW'(BTI_WORD_BYTES - 1);
                issue_cnt <= cmd_len;
                rsp_cnt   <= cmd_len;
            end else begin
                if (req_fire) begin
                    addr_q    <= addr_q + BTI_AW'(BTI_WORD_BYTES);
                    issue_cnt <= issue_cnt - LEN_W'(1);
                end
                if (rsp_fire) begin
                    rsp_cnt <= rsp_cnt - LEN_W'(1);
                end
            end

            if (req_fire) begin
                tid_q <= tid_q + BTI_TIDW'(1);
            end

            case ({req_fire, rsp_fire})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase

            if (cmd_fire) begin
                err_q <= 1'b0;
            end else if (rsp_fire && rsp_bad) begin
                err_q <= 1'b1;
            end
        end
    end

    bti_rsp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (BTI_DW)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rsp_fire),
        .push_data (BTI_DW'(bti_rsp_slv.pkt.data)),
        .pop       (out_vld & out_rdy),
        .pop_data  (out_data),
        .full      (fifo_full_unused),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_bti_burst_rd.sv
// Self-checking bench for bti_burst_rd: slave model with programmable latency
// and a read-data scoreboard filled from each command.
module tb_bti_burst_rd;
    import bti_pkg::*;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned LW    = 16;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_vld;
    logic          cmd_rdy;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          out_vld;
    logic          out_rdy;
    logic [DW-1:0] out_data;
    logic          done;
    logic          err;

    bti_req_if_t req_if ();
    bti_rsp_if_t rsp_if ();

    always #5 clk = ~clk;

    bti_burst_rd #(
        .BTI_AW     (AW),
        .BTI_DW     (DW),
        .LEN_W      (LW),
        .FIFO_DEPTH (DEPTH)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_vld     (cmd_vld),
        .cmd_rdy     (cmd_rdy),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .bti_req_mst (req_if),
        .bti_rsp_slv (rsp_if),
        .out_vld     (out_vld),
        .out_rdy     (out_rdy),
        .out_data    (out_data),
        .done        (done),
        .err         (err)
    );

    typedef struct {
        logic [31:0]         addr;
        logic [BTI_TIDW-1:0] tid;
        int                  due;
    } pend_t;

    pend_t               pend_q[$];
    logic [31:0]         exp_q[$];
    logic [31:0]         exp_addr;
    logic [BTI_TIDW-1:0] exp_tid = '0;
    int                  issued = 0;
    int                  responded = 0;
    int                  popped = 0;
    int                  cyc = 0;
    int                  lat = 1;
    int                  err_idx = -1;
    int                  rsp_in_cmd = 0;
    int                  total = 0;
    int                  bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // Slave and output monitor: observe at negedge, drive just after posedge.
    initial begin
        rsp_if.vld = 1'b0;
        rsp_if.pkt = '0;
        req_if.rdy = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                if (rsp_if.vld) begin
                    chk("rsp_rdy", 64'(rsp_if.rdy), 64'd1);
                    if (pend_q.size() > 0) void'(pend_q.pop_front());
                    responded++;
                    rsp_in_cmd++;
                end
                if (req_if.vld && req_if.rdy) begin
                    chk("req_addr", 64'(req_if.pkt.addr), 64'(exp_addr));
                    chk("req_tid", 64'(req_if.pkt.tid), 64'(exp_tid));
                    chk("req_rd_fields", 64'({req_if.pkt.we, req_if.pkt.be, req_if.pkt.wdata}), 64'd0);
                    pend_q.push_back('{req_if.pkt.addr, req_if.pkt.tid, cyc + lat - 1});
                    exp_addr = exp_addr + 32'd4;
                    exp_tid  = exp_tid + 1'b1;
                    issued++;
                    chk("credit", 64'(issued - popped <= int'(DEPTH)), 64'd1);
                end
                if (out_vld && out_rdy) begin
                    if (exp_q.size() == 0) chk("out_extra", 64'(out_data), 64'hDEAD);
                    else chk("out_data", 64'(out_data), 64'(exp_q.pop_front()));
                    popped++;
                end
            end
            @(posedge clk);
            #1;
            if (pend_q.size() > 0 && cyc >= pend_q[0].due) begin
                rsp_if.vld      = 1'b1;
                rsp_if.pkt.tid  = pend_q[0].tid;
                rsp_if.pkt.data = data_of(pend_q[0].addr);
                rsp_if.pkt.ok   = (rsp_in_cmd != err_idx);
            end else begin
                rsp_if.vld = 1'b0;
            end
        end
    end

    task automatic start_cmd(input logic [31:0] a, input logic [15:0] len);
        int n = 0;
        @(posedge clk);
        #1;
        cmd_vld  = 1'b1;
        cmd_addr = a;
        cmd_len  = len;
        while (1) begin
            @(negedge clk);
            if (cmd_rdy) break;
            n++;
            if (n > 300) begin
                chk("cmd_accept_timeout", 64'd0, 64'd1);
                break;
            end
        end
        exp_addr   = a & ~32'h3;
        rsp_in_cmd = 0;
        for (int i = 0; i < int'(len); i++) exp_q.push_back(data_of(exp_addr + 32'(4 * i)));
        @(posedge clk);
        #1;
        cmd_vld = 1'b0;
    endtask

    task automatic wait_done(input int maxc, input logic exp_err);
        int n = 0;
        while (1) begin
            @(negedge clk);
            if (done) break;
            n++;
            if (n > maxc) begin
                chk("done_timeout", 64'd0, 64'd1);
                return;
            end
        end
        chk("done_err", 64'(err), 64'(exp_err));
        chk("drained", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int i0;
        int n;
        rst_n    = 1'b0;
        cmd_vld  = 1'b0;
        cmd_addr = '0;
        cmd_len  = '0;
        out_rdy  = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_cmd_rdy", 64'(cmd_rdy), 64'd1);
        chk("rst_req_vld", 64'(req_if.vld), 64'd0);
        chk("rst_out_vld", 64'(out_vld), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        // basic burst
        i0 = issued;
        start_cmd(32'h100, 16'd4);
        @(negedge clk);
        chk("basic_err_clear", 64'(err), 64'd0);
        wait_done(100, 1'b0);
        chk("basic_req_count", 64'(issued - i0), 64'd4);

        // zero length
        i0 = issued;
        start_cmd(32'h500, 16'd0);
        @(negedge clk);
        chk("len0_done_c1", 64'(done), 64'd0);
        @(negedge clk);
        chk("len0_done_c2", 64'(done), 64'd1);
        @(negedge clk);
        chk("len0_done_c3", 64'(done), 64'd0);
        chk("len0_no_req", 64'(issued - i0), 64'd0);

        // unaligned start
        start_cmd(32'h203, 16'd2);
        wait_done(100, 1'b0);

        // backpressure
        out_rdy = 1'b0;
        i0 = issued;
        start_cmd(32'h1000, 16'd10);
        repeat (30) @(negedge clk);
        chk("bp_req_count", 64'(issued - i0), 64'd4);
        chk("bp_req_vld_low", 64'(req_if.vld), 64'd0);
        @(posedge clk);
        #1;
        out_rdy = 1'b1;
        wait_done(200, 1'b0);
        chk("bp_total_reqs", 64'(issued - i0), 64'd10);

        // error on second response, then cleared by next command
        err_idx = 1;
        start_cmd(32'h40, 16'd3);
        wait_done(100, 1'b1);
        err_idx = -1;
        start_cmd(32'h80, 16'd1);
        @(negedge clk);
        chk("err_cleared", 64'(err), 64'd0);
        wait_done(100, 1'b0);

        // address wrap; tid has also wrapped past its maximum by now
        start_cmd(32'hFFFF_FFFC, 16'd2);
        wait_done(100, 1'b0);

        // longer slave latency
        lat = 3;
        start_cmd(32'h3000, 16'd6);
        wait_done(200, 1'b0);

        // asynchronous reset with two requests outstanding
        lat = 6;
        i0 = issued;
        start_cmd(32'h7000, 16'd8);
        n = 0;
        while (issued - i0 < 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("mid_two_issued", 64'(issued - i0), 64'd2);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req_vld", 64'(req_if.vld), 64'd0);
        chk("mid_rst_out_vld", 64'(out_vld), 64'd0);
        chk("mid_rst_cmd_rdy", 64'(cmd_rdy), 64'd1);
        pend_q.delete();
        exp_q.delete();
        rsp_if.vld = 1'b0;
        exp_tid    = '0;
        issued     = 0;
        responded  = 0;
        popped     = 0;
        lat        = 1;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        start_cmd(32'h9000, 16'd3);
        wait_done(100, 1'b0);
        chk("post_rst_reqs", 64'(issued), 64'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bti_burst_rd.md
Name: bti_burst_rd

Overview:
- BTI initiator (master) that turns one command (start address, word count) into a stream of single-word BTI read requests, one word per request.
- Collects responses into a local FIFO and presents the read data as a valid/ready stream.
- Sits in front of BTI slaves such as ROM/SRAM bridges; used for boot copy and DMA-style block reads.

Parameters:
- BTI_AW, 32, BTI address width.
- BTI_DW, 32, BTI data width; one word per request.
- LEN_W, 16, width of the command word count.
- FIFO_DEPTH, 4, response buffer depth; power of 2, ≥2. Also the cap on outstanding requests plus buffered words.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_vld  in  1  command valid
- cmd_rdy  out  1  command ready; high only in IDLE
- cmd_addr  in  BTI_AW  start byte address; bits [1:0] ignored (treated as 0)
- cmd_len  in  LEN_W  number of words to read
- bti_req_mst  bti_req_if_t.mst  -  drives vld, pkt.addr, pkt.tid; all other req pkt fields held at 0 (read)
- bti_rsp_slv  bti_rsp_if_t.slv  -  receives vld, pkt.tid, pkt.data, pkt.ok; drives rdy
- out_vld  out  1  read data valid
- out_rdy  in  1  read data ready
- out_data  out  BTI_DW  read data, in address order
- done  out  1  one-cycle pulse when the command completes
- err  out  1  sticky error flag; cleared on the next command accept

Behaviour:
- Clock and reset: single clk. rst_n is asynchronous and active-low.
- Reset values: state=IDLE; cmd_rdy=1; bti_req_mst.vld=0; out_vld=0; done=0; err=0; all counters, pointers and tid=0.
- Handshakes: a transfer occurs when vld&rdy in the same cycle. Once vld is raised it holds, with addr/tid stable, until accepted.
- Command accept (cmd_vld&cmd_rdy):
  - latch addr={cmd_addr[BTI_AW-1:2],2'b00}, issue count = cmd_len, response count = cmd_len; clear err.
  - go to RUN, or to DONE if cmd_len==0.
- RUN:
  - req.vld=1 while issue count>0 and (outstanding+FIFO occupancy) < FIFO_DEPTH.
  - On accept: addr+=4 (wraps modulo 2^BTI_AW), tid+=1 (wraps at 2^BTI_TIDW), issue count-=1.
  - When issue count reaches 0, go to WAIT.
- WAIT: no requests. When response count reaches 0 and the FIFO is empty, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. The next command may be accepted in the following cycle.
- Responses:
  - bti_rsp_slv.rdy=1 always; the credit rule guarantees FIFO space.
  - Each accepted response pushes data into the FIFO and decrements outstanding and response count.
  - ok==0 sets err. Data is still pushed and the burst continues.
- tid rule:
  - Expected tid is an independent counter, incremented per accepted response.
  - Requests and responses are in order; tid is not used for reordering.
- Counter updates: same-cycle req accept and rsp accept leave outstanding unchanged. Same-cycle push and pop leave FIFO occupancy unchanged.
- Latency: first req.vld is asserted the cycle after command accept. out_vld rises the cycle after the first response accept (registered FIFO).
- Backpressure: out_rdy=0 stalls issue once outstanding+occupancy==FIFO_DEPTH. Responses are never dropped.
- Reset mid-burst: all state returns to reset values. In-flight responses are abandoned, so the system resets the slave together with this block.

Optional Feature:
- BTI_BURST_RD_TID_CHK_EN
- Defined: a response whose pkt.tid differs from the expected tid sets err. Data is still pushed and the expected tid still increments.
- Undefined: pkt.tid is ignored and the expected-tid counter is not synthesized.

Decomposition:
- Shared package (bti_pkg / bti.svh): `BTI_TIDW, BTI req/rsp packet typedefs, and localparam BTI_WORD_BYTES=4.
- Local to this block: state enum (IDLE, RUN, WAIT, DONE).
- One sub-module: bti_rsp_fifo. Synchronous FIFO, DEPTH/DW parameters, push/pop/full/empty/count outputs, async active-low reset.

Test Plan:
- Basic burst: cmd addr=0x100, len=4; slave always ready, 1-cycle response; out_rdy=1 -> req addrs 0x100, 0x104, 0x108, 0x10C with tids 0..3; out_data in order; done pulses once; err=0.
- Length zero and unaligned address:
  - len=0 -> no req.vld; done pulses 2 cycles after accept.
  - cmd_addr=0x203 -> first req addr 0x200.
- Backpressure: len=10, FIFO_DEPTH=4, out_rdy=0 -> exactly 4 requests issued, then req.vld=0. Release out_rdy -> all 10 words delivered in order; outstanding+occupancy never exceeds 4.
- Error response: len=3, second response ok=0 -> err=1 after that response; all 3 words delivered; done pulses. err clears on the next command accept.
- Wrap: addr=0xFFFF_FFFC, len=2 -> second req addr 0x0000_0000. Starting tid=2^BTI_TIDW-1 -> next tid 0; with BTI_BURST_RD_TID_CHK_EN defined, no err.
- Async reset mid-burst: rst_n low while RUN with 2 outstanding -> immediately req.vld=0, out_vld=0, cmd_rdy=1. A new burst after reset completes correctly starting at tid 0.
